// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI master types and chip-select decode helper
package spi_pkg;

  localparam int CS_MAX   = 32;
  localparam int CS_SEL_W = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    XFER  = 2'd2,
    HOLD  = 2'd3
  } spi_state_t;

  typedef enum logic [1:0] {
    MODE0 = 2'b00,
    MODE1 = 2'b01,
    MODE2 = 2'b10,
    MODE3 = 2'b11
  } spi_mode_t;

  // One-hot slave select; all zeros when the index is not a real slave.
  function automatic logic [CS_MAX-1:0] cs_decode(input int unsigned sel, input logic valid);
    logic [CS_MAX-1:0] oh;
    oh = '0;
    if (valid && (sel < CS_MAX)) oh[sel[CS_SEL_W-1:0]] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/spi_clk_div.sv
// rtl/spi_clk_div.sv - half-period tick generator for the SPI master
module spi_clk_div #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic             restart_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             tick_o
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;
  logic             wrap;

  assign wrap   = (cnt_q == div_i);
  assign tick_o = en_i && !restart_i && wrap;

  always_comb begin
    cnt_d = cnt_q;
    if (restart_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = wrap ? '0 : cnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/spi_master_ctrl.sv
// rtl/spi_master_ctrl.sv - full-duplex SPI master, all CPOL/CPHA modes; SPI_LOOPBACK_EN adds a loopback input
module spi_master_ctrl #(
  parameter  int DATA_W = 8,
  parameter  int NUM_CS = 2,
  parameter  int DIV_W  = 8,
  localparam int CS_W   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [CS_W-1:0]   cs_sel,
  input  logic              cpol,
  input  logic              cpha,
  input  logic [DIV_W-1:0]  clk_div,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic              sck,
  output logic              mosi,
  input  logic              miso,
`ifdef SPI_LOOPBACK_EN
  input  logic              loopback,
`endif
  output logic [NUM_CS-1:0] cs_n
);

  import spi_pkg::*;

  localparam int                EDGE_W    = $clog2(2 * DATA_W) + 1;
  localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * DATA_W - 1);

  spi_state_t        state_q;
  spi_mode_t         mode_q;
  logic [DIV_W-1:0]  div_q;
  logic [EDGE_W-1:0] edge_q;
  logic [DATA_W-1:0] tx_shift_q;
  logic [DATA_W-1:0] rx_shift_q;
  logic [DATA_W-1:0] rx_data_q;
  logic              tx_ready_q;
  logic              busy_q;
  logic              rx_valid_q;
  logic              sck_q;
  logic              mosi_q;
  logic [NUM_CS-1:0] cs_n_q;

  logic accept;
  logic tick;
  logic rx_bit;
  logic lat_cpol;
  logic lat_cpha;
  logic leading;
  logic last_edge;

  assign accept              = tx_valid && tx_ready_q;
  assign {lat_cpol, lat_cpha} = mode_q;
  assign leading             = ~edge_q[0];
  assign last_edge           = (edge_q == LAST_EDGE);

`ifdef SPI_LOOPBACK_EN
  assign rx_bit = loopback ? mosi_q : miso;
`else
  assign rx_bit = miso;
`endif

  spi_clk_div #(
    .DIV_W(DIV_W)
  ) u_clk_div (
    .clk      (clk),
    .reset    (reset),
    .en_i     (state_q != IDLE),
    .restart_i(accept),
    .div_i    (div_q),
    .tick_o   (tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      mode_q     <= MODE0;
      div_q      <= '0;
      edge_q     <= '0;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      tx_ready_q <= 1'b1;
      busy_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      sck_q      <= 1'b0;
      mosi_q     <= 1'b0;
      cs_n_q     <= '1;
    end else begin
      rx_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q    <= SETUP;
            mode_q     <= spi_mode_t'({cpol, cpha});
            div_q      <= clk_div;
            edge_q     <= '0;
            tx_shift_q <= tx_data;
            rx_shift_q <= '0;
            tx_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            sck_q      <= cpol;
            cs_n_q     <= ~NUM_CS'(cs_decode(32'(cs_sel), 32'(cs_sel) < NUM_CS));
            if (!cpha) mosi_q <= tx_data[DATA_W-1];
          end
        end
        SETUP: begin
          if (tick) state_q <= XFER;
        end
        XFER: begin
          if (tick) begin
            sck_q  <= last_edge ? lat_cpol : ~sck_q;
            edge_q <= edge_q + EDGE_W'(1);
            // Sample edge is leading for CPHA=0 and trailing for CPHA=1; the other edge drives.
            if (leading ^ lat_cpha) begin
              rx_shift_q <= {rx_shift_q[DATA_W-2:0], rx_bit};
            end else if (lat_cpha) begin
              mosi_q     <= tx_shift_q[DATA_W-1];
              tx_shift_q <= tx_shift_q << 1;
            end else if (!last_edge) begin
              mosi_q     <= tx_shift_q[DATA_W-2];
              tx_shift_q <= tx_shift_q << 1;
            end
            if (last_edge) state_q <= HOLD;
          end
        end
        HOLD: begin
          if (tick) begin
            state_q    <= IDLE;
            cs_n_q     <= '1;
            rx_data_q  <= rx_shift_q;
            rx_valid_q <= 1'b1;
            tx_ready_q <= 1'b1;
            busy_q     <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx_ready = tx_ready_q;
  assign busy     = busy_q;
  assign rx_valid = rx_valid_q;
  assign rx_data  = rx_data_q;
  assign sck      = sck_q;
  assign mosi     = mosi_q;
  assign cs_n     = cs_n_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb/tb_spi_master_ctrl.sv - self-checking bench for spi_master_ctrl
`timescale 1ns/1ps
module tb_spi_master_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [0:0] cs_sel = '0;
  logic       cpol = 1'b0;
  logic       cpha = 1'b0;
  logic [7:0] clk_div = '0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       sck;
  logic       mosi;
  logic       miso;
  logic [1:0] cs_n;
`ifdef SPI_LOOPBACK_EN
  logic       loopback = 1'b0;
`endif

  spi_master_ctrl #(
    .DATA_W(8),
    .NUM_CS(2),
    .DIV_W (8)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .cs_sel  (cs_sel),
    .cpol    (cpol),
    .cpha    (cpha),
    .clk_div (clk_div),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .busy    (busy),
    .sck     (sck),
    .mosi    (mosi),
    .miso    (miso),
`ifdef SPI_LOOPBACK_EN
    .loopback(loopback),
`endif
    .cs_n    (cs_n)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic note_fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  typedef struct {
    logic [7:0] rx;
    logic [7:0] tx;
    logic [1:0] csn;
    logic       cpol;
    int         acc;
    int         lat;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic       cpol;
    logic       cpha;
    logic [7:0] div;
    logic       cs;
    logic [7:0] tx;
    logic [7:0] sl;
    logic [1:0] csn;
    logic [7:0] exp_rx;
  } vec_t;
  vec_t vt[7];

  // Slave model: MSB first, bit index derived from SCK edges seen so far.
  logic       cur_cpha = 1'b0;
  logic [7:0] cur_sl = '0;
  int         cur_div = 0;
  logic       miso_zero = 1'b0;
  int         edges = 0;

  function automatic logic slave_bit(input logic [7:0] w, input logic ph, input int e);
    int idx;
    idx = ph ? ((e > 0) ? (e - 1) / 2 : 0) : e / 2;
    if (idx > 7) idx = 7;
    return w[7-idx];
  endfunction

  assign miso = miso_zero ? 1'b0 : slave_bit(cur_sl, cur_cpha, edges);

  logic       sck_p = 1'b0;
  logic       busy_p = 1'b0;
  logic [7:0] mosi_w = '0;
  bit         cs_bad, rdy_bad, hp_bad;
  int         last_edge = 0;
  int         rxv_cnt = 0;

  always @(negedge clk) begin
    if (rx_valid === 1'b1) begin
      rxv_cnt++;
      if (sb.size() == 0) begin
        check("rx_unexpected", 32'(rx_valid), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rx_data", 32'(rx_data), 32'(e.rx));
        check("mosi_bits", 32'(mosi_w), 32'(e.tx));
        check("latency", 32'(cyc - e.acc), 32'(e.lat));
        check("sck_edges", 32'(edges), 32'd16);
        check("sck_half_period", 32'(hp_bad), 32'd0);
        check("cs_n_during", 32'(cs_bad), 32'd0);
        check("ready_low_during", 32'(rdy_bad), 32'd0);
        check("cs_n_after", 32'(cs_n), 32'd3);
        check("sck_idle", 32'(sck), 32'(e.cpol));
      end
    end
    if (busy !== 1'b1) begin
      edges   = 0;
      mosi_w  = '0;
      cs_bad  = 0;
      rdy_bad = 0;
      hp_bad  = 0;
    end else begin
      if (sb.size() > 0 && cs_n !== sb[0].csn) cs_bad = 1;
      if (tx_ready !== 1'b0) rdy_bad = 1;
      if (busy_p && sck !== sck_p) begin
        edges++;
        if (edges > 1 && (cyc - last_edge) != cur_div + 1) hp_bad = 1;
        last_edge = cyc;
        if (edges[0] != cur_cpha) mosi_w = {mosi_w[6:0], mosi};
      end
    end
    busy_p = busy;
    sck_p  = sck;
  end

  logic       acc_rxv;
  logic [1:0] acc_csn;

  task automatic send(input logic p_cpol, input logic p_cpha, input logic [7:0] p_div,
                      input logic p_cs, input logic [7:0] p_tx, input logic [7:0] p_sl,
                      input logic [1:0] p_csn, input logic [7:0] p_exp, input bit hold);
    exp_t e;
    int   n;
    @(negedge clk);
    tx_data  = p_tx;
    cpol     = p_cpol;
    cpha     = p_cpha;
    clk_div  = p_div;
    cs_sel   = p_cs;
    tx_valid = 1'b1;
    n = 0;
    while (tx_ready !== 1'b1 && n < 6000) begin
      @(negedge clk);
      n++;
    end
    if (tx_ready !== 1'b1) begin
      note_fail("accept_timeout");
      tx_valid = 1'b0;
      return;
    end
    acc_rxv  = rx_valid;
    acc_csn  = cs_n;
    cur_cpha = p_cpha;
    cur_sl   = p_sl;
    cur_div  = int'(p_div);
    e.rx   = p_exp;
    e.tx   = p_tx;
    e.csn  = p_csn;
    e.cpol = p_cpol;
    e.acc  = cyc + 1;
    e.lat  = 18 * (int'(p_div) + 1);
    sb.push_back(e);
    if (!hold) begin
      @(negedge clk);
      tx_valid = 1'b0;
    end
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (sb.size() > 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() > 0) begin
      note_fail("wait_done_timeout");
      sb.delete();
    end
  endtask

  initial begin
    int n;
    int k;
    vt[0] = '{1'b0, 1'b0, 8'd1,   1'b0, 8'hA5, 8'h3C, 2'b10, 8'h3C};
    vt[1] = '{1'b1, 1'b1, 8'd0,   1'b1, 8'h81, 8'hFF, 2'b01, 8'hFF};
    vt[2] = '{1'b0, 1'b1, 8'd2,   1'b0, 8'hC3, 8'h5A, 2'b10, 8'h5A};
    vt[3] = '{1'b1, 1'b0, 8'd0,   1'b1, 8'h00, 8'hA5, 2'b01, 8'hA5};
    vt[4] = '{1'b0, 1'b0, 8'd0,   1'b1, 8'hFF, 8'h00, 2'b01, 8'h00};
    vt[5] = '{1'b1, 1'b1, 8'd3,   1'b0, 8'h6E, 8'h91, 2'b10, 8'h91};
    vt[6] = '{1'b1, 1'b0, 8'd255, 1'b0, 8'hB2, 8'h4D, 2'b10, 8'h4D};

    repeat (3) @(negedge clk);
    check("reset_tx_ready", 32'(tx_ready), 32'd1);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_rx_valid", 32'(rx_valid), 32'd0);
    check("reset_rx_data", 32'(rx_data), 32'd0);
    check("reset_sck", 32'(sck), 32'd0);
    check("reset_mosi", 32'(mosi), 32'd0);
    check("reset_cs_n", 32'(cs_n), 32'd3);
    reset = 1'b0;

    for (int i = 0; i < 7; i++) begin
      send(vt[i].cpol, vt[i].cpha, vt[i].div, vt[i].cs, vt[i].tx, vt[i].sl,
           vt[i].csn, vt[i].exp_rx, 1'b0);
      wait_done(6000);
    end

    send(1'b0, 1'b0, 8'd0, 1'b0, 8'h11, 8'h96, 2'b10, 8'h96, 1'b1);
    send(1'b0, 1'b0, 8'd0, 1'b0, 8'h22, 8'h69, 2'b10, 8'h69, 1'b0);
    check("b2b_accept_on_rx_valid", 32'(acc_rxv), 32'd1);
    check("b2b_cs_gap", 32'(acc_csn), 32'd3);
    wait_done(2000);

    send(1'b1, 1'b0, 8'd1, 1'b1, 8'h3C, 8'hC3, 2'b01, 8'hC3, 1'b0);
    repeat (3) @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = 8'hFF;
    cpol     = 1'b0;
    cpha     = 1'b1;
    clk_div  = 8'd0;
    cs_sel   = 1'b0;
    repeat (4) @(negedge clk);
    check("ready_low_mid", 32'(tx_ready), 32'd0);
    tx_valid = 1'b0;
    wait_done(2000);

    send(1'b0, 1'b1, 8'd1, 1'b0, 8'h5B, 8'hE4, 2'b10, 8'hE4, 1'b0);
    n = 0;
    while (edges < 7 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (edges != 7) note_fail("edge7_timeout");
    check("sck_high_at_edge7", 32'(sck), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("midrst_cs_n", 32'(cs_n), 32'd3);
    check("midrst_sck", 32'(sck), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_tx_ready", 32'(tx_ready), 32'd1);
    check("midrst_rx_valid", 32'(rx_valid), 32'd0);
    check("midrst_rx_data", 32'(rx_data), 32'd0);
    sb.delete();
    k = rxv_cnt;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    check("midrst_no_rx_valid", 32'(rxv_cnt - k), 32'd0);
    send(1'b0, 1'b1, 8'd1, 1'b1, 8'hD7, 8'h2B, 2'b01, 8'h2B, 1'b0);
    wait_done(2000);

`ifdef SPI_LOOPBACK_EN
    loopback  = 1'b1;
    miso_zero = 1'b1;
    send(1'b0, 1'b0, 8'd0, 1'b0, 8'h5A, 8'h00, 2'b10, 8'h5A, 1'b0);
    wait_done(2000);
    loopback  = 1'b0;
    miso_zero = 1'b0;
`endif

    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    note_fail("global_timeout");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_master_ctrl.md
Name: spi_master_ctrl

Overview:
Parametrised full-duplex SPI master for the next generation of our serial blocks. It generates a real, divided SCK and supports all four CPOL/CPHA modes. It drives multiple active-low chip selects and captures MISO while shifting out MOSI. It sits between a valid/ready word interface on the core side and the external SPI pins.

Parameters:
DATA_W, 8, bits per transfer word (>=2)
NUM_CS, 2, number of chip-select outputs (>=1)
DIV_W, 8, width of the clock-divider input

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
tx_data  in  DATA_W  word to transmit, MSB first
tx_valid  in  1  request to start a transfer
tx_ready  out  1  high when the block can accept a word (IDLE)
cs_sel  in  $clog2(NUM_CS) (min 1)  target slave index
cpol  in  1  SCK idle level
cpha  in  1  0: sample on leading edge; 1: sample on trailing edge
clk_div  in  DIV_W  SCK half-period = clk_div+1 clk cycles
rx_data  out  DATA_W  word captured from MISO
rx_valid  out  1  one-cycle pulse, rx_data valid
busy  out  1  high from accept until return to IDLE
sck  out  1  SPI clock
mosi  out  1  SPI data out
miso  in  1  SPI data in
cs_n  out  NUM_CS  active-low chip selects

Behaviour:
- Reset values: tx_ready=1, busy=0, rx_valid=0, rx_data=0, sck=0, mosi=0, cs_n=all 1s. Internal latched mode resets to CPOL=0, CPHA=0.
- Accept: a transfer starts on a rising clk edge with tx_valid&&tx_ready. At that edge the block latches tx_data, cs_sel, cpol, cpha and clk_div. Input changes during a transfer have no effect.
- FSM states: IDLE, SETUP, XFER, HOLD.
- IDLE:
  - tx_ready=1; sck holds the latched CPOL.
  - On accept: go to SETUP, drive sck to the new cpol, and assert cs_n[cs_sel]=0.
  - If cs_sel >= NUM_CS, no cs_n is asserted but the transfer still runs.
- SETUP: lasts one half-period.
  - CPHA=0: mosi = tx_data[DATA_W-1] throughout SETUP.
  - CPHA=1: mosi is not updated.
- XFER: 2*DATA_W half-periods; sck toggles at the end of each half-period. The leading edge is the transition away from CPOL.
  - CPHA=0: sample miso on leading edges; shift mosi to the next bit on trailing edges, except after the final edge.
  - CPHA=1: drive the next bit on leading edges; sample miso on trailing edges.
- HOLD:
  - Lasts one half-period, with sck at CPOL and cs_n still asserted.
  - At the end: all cs_n=1, rx_data is updated, rx_valid pulses for 1 cycle, and the FSM returns to IDLE.
- Latency: rx_valid goes high exactly (2*DATA_W+2)*(clk_div+1) cycles after the accepting edge. tx_ready=1 in that same cycle, so back-to-back accepts are legal. cs_n deasserts for at least one cycle between words.
- Counters:
  - Divider counter: DIV_W bits, wraps at the latched clk_div; clk_div=0 gives sck = clk/2.
  - Edge counter: $clog2(2*DATA_W)+1 bits, so there is no overflow.
- tx_valid while busy is ignored (no queueing).
- Reset asserted mid-transfer: all outputs return to reset values immediately (async) and any partial rx word is discarded.
- miso is sampled directly; the integrator synchronises it if needed.

Optional Feature:
Macro SPI_LOOPBACK_EN.
- Defined: adds input port loopback (1 bit). When loopback=1, the receive shifter samples the internal mosi instead of miso, so rx_data equals tx_data after each transfer. When loopback=0, behaviour is unchanged.
- Not defined: the port is absent and miso is always sampled.

Decomposition:
- Package spi_pkg holds:
  - the state enum spi_state_t (IDLE, SETUP, XFER, HOLD), 2-bit;
  - the mode enum spi_mode_t (MODE0..MODE3 as {cpol,cpha});
  - the function cs_decode(sel, valid).
- Sub-module spi_clk_div: a half-period divider with enable and restart inputs, producing a one-cycle tick at each half-period end. The FSM consumes only the ticks.

Test Plan:
- Mode 0, clk_div=1, tx_data=0xA5, miso shifts 0x3C -> mosi bits 1,0,1,0,0,1,0,1; 8 sck pulses of period 4 clk; cs_n=2'b10; rx_data=0x3C; rx_valid 36 cycles after accept.
- Mode 3, clk_div=0, cs_sel=1, tx_data=0x81, miso=0xFF -> sck idles 1; mosi changes on falling edges; cs_n=2'b01; rx_data=0xFF at cycle 18.
- Back-to-back: tx_valid held high with 0x11 then 0x22 -> second accept in the same cycle as the first rx_valid; cs_n high at least 1 cycle between words; rx order preserved.
- tx_valid pulsed and tx_data/cpol changed mid-transfer -> transfer unaffected, tx_ready=0 throughout.
- Reset asserted at edge 7 of a mode-1 transfer -> cs_n=all 1, sck=0, no rx_valid; the next transfer after release completes correctly.
- SPI_LOOPBACK_EN defined, loopback=1, tx_data=0x5A, miso tied 0 -> rx_data=0x5A.
